// File: rtl/skp_os_detect_if.sv
// Symbol bus between the elastic buffer side and deskew_fifo side of one lane.
// The slave view belongs to skp_os_detect and the master view belongs to the lane control and consumer.
interface skp_os_detect_if;
  logic [7:0] eb_data;
  logic       eb_k;
  logic       lane_clr;
  logic [7:0] w_data;
  logic       com_ahead;
  logic       SOS_ahead;
  logic [2:0] window_cnt;
  logic       sos_err;

  modport slave (
    input  eb_data, eb_k, lane_clr,
    output w_data, com_ahead, SOS_ahead, window_cnt, sos_err
  );

  modport master (
    output eb_data, eb_k, lane_clr,
    input  w_data, com_ahead, SOS_ahead, window_cnt, sos_err
  );
endinterface

// File: rtl/skp_os_detect.sv
// Per-lane SKP ordered-set classifier: two-stage symbol delay with COM/SOS tags,
// SOS length checking and the saturating legal-SOS window counter that enables deskew.
module skp_os_detect #(
  parameter logic [7:0] COM_SYM = 8'hBC,
  parameter logic [7:0] SKP_SYM = 8'h1C,
  parameter int         MIN_SKP = 1,
  parameter int         MAX_SKP = 5
) (
  input  logic           clk_r_local,
  input  logic           rstn,
  skp_os_detect_if.slave bus
);

  localparam logic [2:0] MIN_RUN = 3'(MIN_SKP);
  localparam logic [2:0] MAX_RUN = 3'(MAX_SKP);
  localparam logic [2:0] WIN_SAT = 3'd4;
  localparam logic [2:0] RUN_SAT = 3'd7;

  typedef enum logic {IDLE, IN_SOS} state_e;

  logic [8:0] s1_q, s1_d;
  logic [7:0] s2_q, s2_d;
  logic       com_q, com_d;
  logic       sos_q, sos_d;
  logic       err_q, err_d;
  logic [2:0] win_q, win_d;
  logic [2:0] run_q, run_d;
  logic [2:0] run_inc;
  state_e     state_q, state_d;

  logic eb_skp, s1_com, s1_skp, s1_sos;
  logic run_legal;

  assign eb_skp    = bus.eb_k && (bus.eb_data == SKP_SYM);
  assign s1_com    = s1_q[8] && (s1_q[7:0] == COM_SYM);
  assign s1_skp    = s1_q[8] && (s1_q[7:0] == SKP_SYM);
  // SOS needs a one-symbol lookahead: COM in s1 with SKP arriving from the EB.
  assign s1_sos    = s1_com && eb_skp;
  assign run_inc   = (run_q == RUN_SAT) ? RUN_SAT : run_q + 3'd1;
  assign run_legal = (run_q >= MIN_RUN) && (run_q <= MAX_RUN);

  always_comb begin
    s1_d  = {bus.eb_k, bus.eb_data};
    s2_d  = s1_q[7:0];
    com_d = s1_com;
    sos_d = s1_sos;
  end

  // The FSM looks at s1, the symbol that lands on w_data at this edge, so a
  // window_cnt update is visible together with that symbol and any COM that follows.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    win_d   = win_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s1_sos) begin
          state_d = IN_SOS;
          run_d   = 3'd0;
        end
      end
      IN_SOS: begin
        if (s1_skp) begin
          if (run_inc > MAX_RUN) begin
            err_d   = 1'b1;
            win_d   = 3'd0;
            state_d = IDLE;
          end else begin
            run_d = run_inc;
          end
        end else begin
          if (run_legal) begin
            win_d = (win_q == WIN_SAT) ? WIN_SAT : win_q + 3'd1;
          end else begin
            err_d = 1'b1;
            win_d = 3'd0;
          end
          if (s1_sos) begin
            state_d = IN_SOS;
            run_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Link control clear overrides any close or error decided this cycle.
    if (bus.lane_clr) begin
      state_d = IDLE;
      run_d   = 3'd0;
      win_d   = 3'd0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_r_local or negedge rstn) begin
    if (!rstn) begin
      s1_q    <= '0;
      s2_q    <= '0;
      com_q   <= 1'b0;
      sos_q   <= 1'b0;
      err_q   <= 1'b0;
      win_q   <= '0;
      run_q   <= '0;
      state_q <= IDLE;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      com_q   <= com_d;
      sos_q   <= sos_d;
      err_q   <= err_d;
      win_q   <= win_d;
      run_q   <= run_d;
      state_q <= state_d;
    end
  end

  assign bus.w_data     = s2_q;
  assign bus.com_ahead  = com_q;
  assign bus.SOS_ahead  = sos_q;
  assign bus.window_cnt = win_q;
  assign bus.sos_err    = err_q;

endmodule

// File: tb/tb_skp_os_detect.sv
// Directed bench for skp_os_detect: pipeline delay, SOS tagging, window counting,
// length errors, back-to-back SOS, lane_clr priority and async reset.
module tb_skp_os_detect;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] DD  = 8'h4A;

  logic clk_r_local = 1'b0;
  logic rstn        = 1'b0;
  int   checks      = 0;
  int   failures    = 0;

  always #5 clk_r_local = ~clk_r_local;

  skp_os_detect_if bus();

  skp_os_detect dut (
    .clk_r_local(clk_r_local),
    .rstn       (rstn),
    .bus        (bus)
  );

  // After push returns, w_data/tags/window_cnt all describe the previously pushed symbol.
  task automatic push(input logic [7:0] d, input logic k, input logic clr);
    bus.eb_data  = d;
    bus.eb_k     = k;
    bus.lane_clr = clr;
    @(posedge clk_r_local);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({bus.w_data, bus.com_ahead, bus.SOS_ahead, bus.window_cnt, bus.sos_err} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got w=%h c=%b s=%b win=%0d e=%b exp all 0",
               bus.w_data, bus.com_ahead, bus.SOS_ahead, bus.window_cnt, bus.sos_err);
    end
    @(negedge clk_r_local);
    rstn = 1'b1;
  endtask

  task automatic test_dchars;
    logic [7:0] exp_w;
    for (int i = 0; i < 10; i++) begin
      push(DD, 1'b0, 1'b0);
      exp_w = (i == 0) ? 8'h00 : DD;
      checks++;
      if (bus.w_data !== exp_w) begin
        failures++;
        $display("FAIL dchar_w_data cyc%0d got %h exp %h", i, bus.w_data, exp_w);
      end
      checks++;
      if ({bus.com_ahead, bus.SOS_ahead, bus.window_cnt, bus.sos_err} !== 6'd0) begin
        failures++;
        $display("FAIL dchar_tags cyc%0d got c=%b s=%b win=%0d e=%b exp 0", i,
                 bus.com_ahead, bus.SOS_ahead, bus.window_cnt, bus.sos_err);
      end
    end
  endtask

  task automatic test_sos_window;
    logic [2:0] exp_win;
    for (int set = 1; set <= 5; set++) begin
      exp_win = (set > 4) ? 3'd4 : 3'(set);
      push(COM, 1'b1, 1'b0);
      push(SKP, 1'b1, 1'b0);
      checks++;
      if ({bus.w_data, bus.com_ahead, bus.SOS_ahead} !== {COM, 2'b11}) begin
        failures++;
        $display("FAIL sos_tag set%0d got w=%h c=%b s=%b exp w=bc c=1 s=1", set,
                 bus.w_data, bus.com_ahead, bus.SOS_ahead);
      end
      push(SKP, 1'b1, 1'b0);
      push(SKP, 1'b1, 1'b0);
      push(DD, 1'b0, 1'b0);
      checks++;
      if (bus.window_cnt !== ((set > 4) ? 3'd4 : 3'(set - 1))) begin
        failures++;
        $display("FAIL sos_win_hold set%0d got %0d exp %0d", set, bus.window_cnt,
                 (set > 4) ? 4 : set - 1);
      end
      push(DD, 1'b0, 1'b0);
      checks++;
      if ({bus.window_cnt, bus.sos_err} !== {exp_win, 1'b0}) begin
        failures++;
        $display("FAIL sos_win set%0d got win=%0d e=%b exp win=%0d e=0", set,
                 bus.window_cnt, bus.sos_err, exp_win);
      end
    end
  endtask

  task automatic test_com_not_sos;
    push(COM, 1'b1, 1'b0);
    push(DD, 1'b0, 1'b0);
    checks++;
    if ({bus.w_data, bus.com_ahead, bus.SOS_ahead, bus.sos_err} !== {COM, 3'b100}) begin
      failures++;
      $display("FAIL lone_com got w=%h c=%b s=%b e=%b exp w=bc c=1 s=0 e=0",
               bus.w_data, bus.com_ahead, bus.SOS_ahead, bus.sos_err);
    end
    push(DD, 1'b0, 1'b0);
    checks++;
    if ({bus.window_cnt, bus.sos_err, bus.com_ahead} !== {3'd4, 2'b00}) begin
      failures++;
      $display("FAIL lone_com_win got win=%0d e=%b c=%b exp win=4 e=0 c=0",
               bus.window_cnt, bus.sos_err, bus.com_ahead);
    end
  endtask

  task automatic test_overlong;
    push(DD, 1'b0, 1'b1);
    checks++;
    if (bus.window_cnt !== 3'd0) begin
      failures++;
      $display("FAIL clr_win got %0d exp 0", bus.window_cnt);
    end
    push(DD, 1'b0, 1'b0);
    // five SKPs is the longest legal SOS
    push(COM, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push(SKP, 1'b1, 1'b0);
    push(DD, 1'b0, 1'b0);
    push(DD, 1'b0, 1'b0);
    checks++;
    if ({bus.window_cnt, bus.sos_err} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL max_skp_legal got win=%0d e=%b exp win=1 e=0", bus.window_cnt, bus.sos_err);
    end
    for (int s = 0; s < 2; s++) begin
      push(COM, 1'b1, 1'b0);
      push(SKP, 1'b1, 1'b0);
      push(DD, 1'b0, 1'b0);
      push(DD, 1'b0, 1'b0);
    end
    checks++;
    if (bus.window_cnt !== 3'd3) begin
      failures++;
      $display("FAIL min_skp_win got %0d exp 3", bus.window_cnt);
    end
    push(COM, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) push(SKP, 1'b1, 1'b0);
    checks++;
    if ({bus.window_cnt, bus.sos_err} !== {3'd3, 1'b0}) begin
      failures++;
      $display("FAIL overlong_pre got win=%0d e=%b exp win=3 e=0", bus.window_cnt, bus.sos_err);
    end
    push(DD, 1'b0, 1'b0);
    checks++;
    if ({bus.w_data, bus.window_cnt, bus.sos_err} !== {SKP, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL overlong_err got w=%h win=%0d e=%b exp w=1c win=0 e=1",
               bus.w_data, bus.window_cnt, bus.sos_err);
    end
    push(DD, 1'b0, 1'b0);
    checks++;
    if ({bus.window_cnt, bus.sos_err} !== {3'd0, 1'b0}) begin
      failures++;
      $display("FAIL overlong_post got win=%0d e=%b exp win=0 e=0", bus.window_cnt, bus.sos_err);
    end
  endtask

  task automatic test_back_to_back;
    push(COM, 1'b1, 1'b0);
    push(SKP, 1'b1, 1'b0);
    push(COM, 1'b1, 1'b0);
    push(SKP, 1'b1, 1'b0);
    checks++;
    if ({bus.w_data, bus.com_ahead, bus.SOS_ahead, bus.window_cnt, bus.sos_err} !==
        {COM, 2'b11, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first got w=%h c=%b s=%b win=%0d e=%b exp w=bc c=1 s=1 win=1 e=0",
               bus.w_data, bus.com_ahead, bus.SOS_ahead, bus.window_cnt, bus.sos_err);
    end
    push(SKP, 1'b1, 1'b0);
    push(DD, 1'b0, 1'b0);
    push(DD, 1'b0, 1'b0);
    checks++;
    if ({bus.window_cnt, bus.sos_err} !== {3'd2, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second got win=%0d e=%b exp win=2 e=0", bus.window_cnt, bus.sos_err);
    end
  endtask

  task automatic test_clr_and_reset;
    push(COM, 1'b1, 1'b0);
    push(SKP, 1'b1, 1'b0);
    push(DD, 1'b0, 1'b0);
    push(DD, 1'b0, 1'b1);
    checks++;
    if ({bus.w_data, bus.window_cnt, bus.sos_err} !== {DD, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL clr_vs_close got w=%h win=%0d e=%b exp w=4a win=0 e=0",
               bus.w_data, bus.window_cnt, bus.sos_err);
    end
    push(DD, 1'b0, 1'b0);
    push(COM, 1'b1, 1'b0);
    push(SKP, 1'b1, 1'b0);
    push(DD, 1'b0, 1'b0);
    push(DD, 1'b0, 1'b0);
    checks++;
    if (bus.window_cnt !== 3'd1) begin
      failures++;
      $display("FAIL clr_recount got %0d exp 1", bus.window_cnt);
    end
    push(COM, 1'b1, 1'b0);
    push(SKP, 1'b1, 1'b0);
    push(SKP, 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.w_data, bus.com_ahead, bus.SOS_ahead, bus.window_cnt, bus.sos_err} !== 14'd0) begin
      failures++;
      $display("FAIL async_reset got w=%h c=%b s=%b win=%0d e=%b exp all 0",
               bus.w_data, bus.com_ahead, bus.SOS_ahead, bus.window_cnt, bus.sos_err);
    end
    @(negedge clk_r_local);
    rstn = 1'b1;
    push(COM, 1'b1, 1'b0);
    push(SKP, 1'b1, 1'b0);
    push(DD, 1'b0, 1'b0);
    push(DD, 1'b0, 1'b0);
    checks++;
    if ({bus.window_cnt, bus.sos_err} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_count got win=%0d e=%b exp win=1 e=0", bus.window_cnt, bus.sos_err);
    end
  endtask

  initial begin
    bus.eb_data  = 8'h00;
    bus.eb_k     = 1'b0;
    bus.lane_clr = 1'b0;
    test_reset;
    test_dchars;
    test_sos_window;
    test_com_not_sos;
    test_overlong;
    test_back_to_back;
    test_clr_and_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
